// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between a timer controller and bcd_countdown_timer.
// Master drives the strobes and preset; slave returns count and flags.
interface bcd_countdown_timer_if #(
   parameter int MIN_DIGITS = 1
);
   localparam int W = 4 * (MIN_DIGITS + 2);

   logic         tick;
   logic         load;
   logic [W-1:0] preset_bcd;
   logic         start;
   logic         pause;
   logic         count_up;
   logic [W-1:0] digits_bcd;
   logic         running;
   logic         zero;
   logic         expired;
   logic         alarm;

   modport master (
      output tick, load, preset_bcd, start, pause, count_up,
      input  digits_bcd, running, zero, expired, alarm
   );

   modport slave (
      input  tick, load, preset_bcd, start, pause, count_up,
      output digits_bcd, running, zero, expired, alarm
   );
endinterface

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD up/down timer stepped by a one-cycle tick strobe, with preset
// load, start/pause control and expired/alarm flags.
module bcd_countdown_timer #(
   parameter int MIN_DIGITS = 1
) (
   input logic                  clk,
   input logic                  reset,
   bcd_countdown_timer_if.slave bus
);
   localparam int NDIG = MIN_DIGITS + 2;
   localparam int W    = 4 * NDIG;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_t;

   state_t       state_q, state_d;
   logic [W-1:0] digits_q, digits_d;
   logic         mode_q, mode_d;
   logic         expired_q, expired_d;
   logic         alarm_q, alarm_d;
   logic         running_q, running_d;

   logic [W-1:0] preset_san;
   logic [W-1:0] cnt_dn;
   logic [W-1:0] cnt_up;
   logic [W-1:0] full_scale;
   logic [W-1:0] cnt_nxt;
   logic         zero_w;
   logic         full_w;
   logic         start_ok;
   logic         term_nxt;

   // Per-digit limits: seconds tens rolls at 5, every other digit at 9.
   always_comb begin
      logic       b;
      logic       c;
      logic [3:0] d;
      logic [3:0] lim;
      cnt_dn     = digits_q;
      cnt_up     = digits_q;
      full_scale = '0;
      preset_san = '0;
      b          = 1'b1;
      c          = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         lim = (i == 1) ? 4'd5 : 4'd9;
         full_scale[4*i +: 4] = lim;
         d = bus.preset_bcd[4*i +: 4];
         preset_san[4*i +: 4] = (d > lim) ? lim : d;
         d = digits_q[4*i +: 4];
         if (b) begin
            if (d == 4'd0) begin
               cnt_dn[4*i +: 4] = lim;
            end else begin
               cnt_dn[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end
         if (c) begin
            if (d >= lim) begin
               cnt_up[4*i +: 4] = 4'd0;
            end else begin
               cnt_up[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end
      end
   end

   assign zero_w   = (digits_q == '0);
   assign full_w   = (digits_q == full_scale);
   assign start_ok = bus.count_up ? !full_w : !zero_w;
   assign cnt_nxt  = mode_q ? cnt_up : cnt_dn;
   assign term_nxt = mode_q ? (cnt_up == full_scale)
                            : (cnt_dn == '0);

   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      mode_d    = mode_q;
      expired_d = 1'b0;
      alarm_d   = alarm_q;
      unique case (state_q)
         RUN: begin
            if (bus.pause) begin
               state_d = PAUSE;
            end else if (bus.tick) begin
               digits_d = cnt_nxt;
               if (term_nxt) begin
                  state_d   = DONE;
                  expired_d = 1'b1;
                  alarm_d   = 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.load) begin
               digits_d = preset_san;
               state_d  = IDLE;
               alarm_d  = 1'b0;
            end
         end
         default: begin
            // IDLE or PAUSE; in PAUSE a concurrent pause masks start.
            if (bus.load) begin
               digits_d = preset_san;
               state_d  = IDLE;
               alarm_d  = 1'b0;
            end else if (state_q == PAUSE && bus.pause) begin
               state_d = PAUSE;
            end else if (bus.start && start_ok) begin
               state_d = RUN;
               mode_d  = bus.count_up;
            end
         end
      endcase
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         digits_q  <= '0;
         mode_q    <= 1'b0;
         expired_q <= 1'b0;
         alarm_q   <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
         alarm_q   <= alarm_d;
         running_q <= running_d;
      end
   end

   assign bus.digits_bcd = digits_q;
   assign bus.running    = running_q;
   assign bus.zero       = zero_w;
   assign bus.expired    = expired_q;
   assign bus.alarm      = alarm_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: directed scenarios plus random stimulus against
// a seconds-valued reference model.
module tb_bcd_countdown_timer;
   localparam int MD   = 1;
   localparam int W    = 4 * (MD + 2);
   localparam int FULL = (10 ** MD - 1) * 60 + 59;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   bcd_countdown_timer_if #(.MIN_DIGITS(MD)) bus ();

   bcd_countdown_timer #(.MIN_DIGITS(MD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: count held as plain seconds.
   int m_val;
   int m_st;
   bit m_up;
   bit m_alarm;
   bit m_exp;

   function automatic int san_val(input logic [W-1:0] p);
      int s1;
      int s10;
      int mn;
      int d;
      s1  = int'(p[3:0]);
      s10 = int'(p[7:4]);
      if (s1 > 9) s1 = 9;
      if (s10 > 5) s10 = 5;
      mn = 0;
      for (int i = MD - 1; i >= 0; i--) begin
         d = int'(p[8+4*i +: 4]);
         if (d > 9) d = 9;
         mn = mn * 10 + d;
      end
      return mn * 60 + s10 * 10 + s1;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int           mn;
      r      = '0;
      r[3:0] = 4'((v % 60) % 10);
      r[7:4] = 4'((v % 60) / 10);
      mn     = v / 60;
      for (int i = 0; i < MD; i++) begin
         r[8+4*i +: 4] = 4'(mn % 10);
         mn = mn / 10;
      end
      return r;
   endfunction

   function automatic logic [W+3:0] exp_bundle();
      return {to_bcd(m_val), m_st == 1, m_val == 0, m_exp, m_alarm};
   endfunction

   task automatic model(input bit rs, tk, ld, st, ps, cu,
                        input logic [W-1:0] pr);
      m_exp = 1'b0;
      if (rs) begin
         m_val = 0; m_st = 0; m_up = 0; m_alarm = 0;
      end else if (m_st == 1) begin
         if (ps) m_st = 2;
         else if (tk) begin
            m_val = m_up ? m_val + 1 : m_val - 1;
            if ((m_up && m_val == FULL) || (!m_up && m_val == 0)) begin
               m_st = 3; m_exp = 1; m_alarm = 1;
            end
         end
      end else if (ld) begin
         m_val = san_val(pr); m_st = 0; m_alarm = 0;
      end else if (m_st == 3) begin
         m_st = 3;
      end else if (m_st == 2 && ps) begin
         m_st = 2;
      end else if (st && (cu ? m_val != FULL : m_val != 0)) begin
         m_st = 1; m_up = cu;
      end
   endtask

   task automatic step(input bit rs, tk, ld, st, ps, cu,
                       input logic [W-1:0] pr);
      reset        = rs;
      bus.tick     = tk;
      bus.load     = ld;
      bus.start    = st;
      bus.pause    = ps;
      bus.count_up = cu;
      bus.preset_bcd = pr;
      @(posedge clk);
      model(rs, tk, ld, st, ps, cu, pr);
      #1;
      reset     = 1'b0;
      bus.tick  = 1'b0;
      bus.load  = 1'b0;
      bus.start = 1'b0;
      bus.pause = 1'b0;
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic do_load(input logic [W-1:0] p);
      step(0, 0, 1, 0, 0, 0, p);
   endtask

   task automatic do_start(input bit cu);
      step(0, 0, 0, 1, 0, cu, '0);
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, '0);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({bus.digits_bcd, bus.running, bus.expired, bus.alarm}
          !== {12'h000, 3'b000}) begin
         n_err++;
         $display("FAIL reset: got %h/%b%b%b want 000/000",
                  bus.digits_bcd, bus.running, bus.expired, bus.alarm);
      end
      n_vec++;
      if (bus.zero !== 1'b1) begin
         n_err++;
         $display("FAIL reset_zero: got %b want 1", bus.zero);
      end
   endtask

   task automatic test_down_expire();
      do_reset();
      do_load(12'h100);
      do_start(0);
      do_ticks(1);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h059, 1'b1}) begin
         n_err++;
         $display("FAIL down_first: got %h/%b want 059/1",
                  bus.digits_bcd, bus.running);
      end
      do_ticks(58);
      n_vec++;
      if ({bus.digits_bcd, bus.expired} !== {12'h001, 1'b0}) begin
         n_err++;
         $display("FAIL down_001: got %h/%b want 001/0",
                  bus.digits_bcd, bus.expired);
      end
      do_ticks(1);
      n_vec++;
      if ({bus.digits_bcd, bus.running, bus.expired, bus.alarm}
          !== {12'h000, 3'b011}) begin
         n_err++;
         $display("FAIL down_term: got %h/%b%b%b want 000/011",
                  bus.digits_bcd, bus.running, bus.expired, bus.alarm);
      end
      do_ticks(1);
      n_vec++;
      if ({bus.digits_bcd, bus.expired, bus.alarm}
          !== {12'h000, 2'b01}) begin
         n_err++;
         $display("FAIL down_hold: got %h/%b%b want 000/01",
                  bus.digits_bcd, bus.expired, bus.alarm);
      end
      do_load(12'h005);
      n_vec++;
      if ({bus.digits_bcd, bus.alarm} !== {12'h005, 1'b0}) begin
         n_err++;
         $display("FAIL done_load: got %h/%b want 005/0",
                  bus.digits_bcd, bus.alarm);
      end
   endtask

   task automatic test_pause();
      do_reset();
      do_load(12'h230);
      do_start(0);
      do_ticks(5);
      step(0, 0, 0, 0, 1, 0, '0);
      do_ticks(10);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h225, 1'b0}) begin
         n_err++;
         $display("FAIL pause_hold: got %h/%b want 225/0",
                  bus.digits_bcd, bus.running);
      end
      do_start(0);
      do_ticks(1);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h224, 1'b1}) begin
         n_err++;
         $display("FAIL resume: got %h/%b want 224/1",
                  bus.digits_bcd, bus.running);
      end
      do_load(12'h111);
      n_vec++;
      if (bus.digits_bcd !== 12'h224) begin
         n_err++;
         $display("FAIL load_in_run: got %h want 224", bus.digits_bcd);
      end
   endtask

   task automatic test_sanitise();
      do_reset();
      do_load(12'h1A7);
      n_vec++;
      if (bus.digits_bcd !== 12'h157) begin
         n_err++;
         $display("FAIL san_1A7: got %h want 157", bus.digits_bcd);
      end
      do_load(12'hFFF);
      n_vec++;
      if (bus.digits_bcd !== 12'h959) begin
         n_err++;
         $display("FAIL san_FFF: got %h want 959", bus.digits_bcd);
      end
   endtask

   task automatic test_up();
      do_reset();
      do_load(12'h958);
      do_start(1);
      do_ticks(1);
      n_vec++;
      if ({bus.digits_bcd, bus.running, bus.expired, bus.alarm}
          !== {12'h959, 3'b011}) begin
         n_err++;
         $display("FAIL up_term: got %h/%b%b%b want 959/011",
                  bus.digits_bcd, bus.running, bus.expired, bus.alarm);
      end
      do_ticks(3);
      do_start(1);
      n_vec++;
      if ({bus.digits_bcd, bus.running, bus.expired}
          !== {12'h959, 2'b00}) begin
         n_err++;
         $display("FAIL up_done: got %h/%b%b want 959/00",
                  bus.digits_bcd, bus.running, bus.expired);
      end
      do_load(12'h059);
      do_start(1);
      do_ticks(1);
      n_vec++;
      if (bus.digits_bcd !== 12'h100) begin
         n_err++;
         $display("FAIL up_carry: got %h want 100", bus.digits_bcd);
      end
   endtask

   task automatic test_refuse();
      do_reset();
      do_load(12'h000);
      do_start(0);
      n_vec++;
      if ({bus.running, bus.expired} !== 2'b00) begin
         n_err++;
         $display("FAIL refuse_zero: got %b%b want 00",
                  bus.running, bus.expired);
      end
      do_load(12'h959);
      do_start(1);
      n_vec++;
      if (bus.running !== 1'b0) begin
         n_err++;
         $display("FAIL refuse_full: got %b want 0", bus.running);
      end
      step(0, 0, 1, 1, 0, 0, 12'h010);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h010, 1'b0}) begin
         n_err++;
         $display("FAIL load_start: got %h/%b want 010/0",
                  bus.digits_bcd, bus.running);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      do_load(12'h043);
      do_start(0);
      do_ticks(1);
      do_reset();
      n_vec++;
      if ({bus.digits_bcd, bus.running, bus.alarm}
          !== {12'h000, 2'b00}) begin
         n_err++;
         $display("FAIL reset_run: got %h/%b%b want 000/00",
                  bus.digits_bcd, bus.running, bus.alarm);
      end
      do_load(12'h010);
      step(0, 1, 0, 1, 0, 0, '0);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h010, 1'b1}) begin
         n_err++;
         $display("FAIL start_tick: got %h/%b want 010/1",
                  bus.digits_bcd, bus.running);
      end
      do_ticks(1);
      step(0, 1, 0, 0, 1, 0, '0);
      n_vec++;
      if ({bus.digits_bcd, bus.running} !== {12'h009, 1'b0}) begin
         n_err++;
         $display("FAIL pause_tick: got %h/%b want 009/0",
                  bus.digits_bcd, bus.running);
      end
      step(0, 0, 0, 1, 1, 0, '0);
      n_vec++;
      if (bus.running !== 1'b0) begin
         n_err++;
         $display("FAIL pause_start: got %b want 0", bus.running);
      end
   endtask

   task automatic test_random();
      logic [W+3:0] want;
      logic [W-1:0] pr;
      bit           ld;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         ld = ($urandom_range(0, 39) == 0);
         pr = W'($urandom);
         if ($urandom_range(0, 3) == 0) pr = to_bcd($urandom_range(0, 5));
         step(($urandom_range(0, 499) == 0),
              ($urandom_range(0, 1) == 0), ld,
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 19) == 0),
              1'($urandom_range(0, 1)), pr);
         want = exp_bundle();
         n_vec++;
         if ({bus.digits_bcd, bus.running, bus.zero,
              bus.expired, bus.alarm} !== want) begin
            n_err++;
            $display("FAIL random[%0d]: got %h/%b%b%b%b want %h/%b",
                     i, bus.digits_bcd, bus.running, bus.zero,
                     bus.expired, bus.alarm, want[W+3:4], want[3:0]);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_val = 0; m_st = 0; m_up = 0; m_alarm = 0; m_exp = 0;
      reset = 1'b1;
      bus.tick = 0; bus.load = 0; bus.start = 0;
      bus.pause = 0; bus.count_up = 0; bus.preset_bcd = '0;
      @(negedge clk);
      test_reset();
      test_down_expire();
      test_pause();
      test_sanitise();
      test_up();
      test_refuse();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
